fc_loader: RTL

Upstream sequencer for the fully-connected stage. It reads three show-ahead FIFOs (weights, biases, activation operands) and presents 32-bit words to the FC stage in the fixed order weights → biases → operands for each 4-lane group. After each operand word it waits for the FC stage's per-group acknowledge (`in_rd_en`). It counts groups until FC_TOTAL_COUNT elements have been issued, then signals done.

---
 rtl/fc_pkg.sv | 28 ++
 rtl/fc_group_counter.sv | 33 +++
 rtl/fc_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected stage: loader state encoding,
// word/lane geometry and a lane-packing helper.
package fc_pkg;

  localparam int FC_WORD_WIDTH = 32;
  localparam int FC_LANES      = 4;
  localparam int FC_LANE_WIDTH = FC_WORD_WIDTH / FC_LANES;

  typedef enum logic [2:0] {
    FC_IDLE     = 3'd0,
    FC_LOAD_W   = 3'd1,
    FC_LOAD_B   = 3'd2,
    FC_LOAD_OP  = 3'd3,
    FC_WAIT_ACK = 3'd4,
    FC_DONE     = 3'd5
  } fc_loader_state_t;

  // Lane 0 occupies the least significant bits of the word.
  function automatic logic [FC_WORD_WIDTH-1:0] fc_pack_lanes(
    input logic [FC_LANE_WIDTH-1:0] lane0,
    input logic [FC_LANE_WIDTH-1:0] lane1,
    input logic [FC_LANE_WIDTH-1:0] lane2,
    input logic [FC_LANE_WIDTH-1:0] lane3
  );
    return {lane3, lane2, lane1, lane0};
  endfunction

endpackage

// File: rtl/fc_group_counter.sv
// Group counter with synchronous clear/increment and an equality-based terminal flag.
// Shared by the loader and the FC stage; it holds at TERMINAL rather than wrapping.
module fc_group_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] TERMINAL_VALUE = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count_r;

  // Count register: cleared by reset or clear, advanced by inc below the terminal value.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (inc && (count_r != TERMINAL_VALUE)) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count    = count_r;
  assign terminal = (count_r == TERMINAL_VALUE);

endmodule

// File: rtl/fc_loader.sv
// Sequences weight, bias and operand words from three show-ahead FIFOs into the FC stage,
// one 4-lane group at a time. Define FC_LOADER_ZERO_BIAS_EN to drop the bias phase.
module fc_loader
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FC_TOTAL_COUNT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [FC_WORD_WIDTH-1:0] w_dout,
  input  logic                     w_empty,
  output logic                     w_rd_en,
  input  logic [FC_WORD_WIDTH-1:0] b_dout,
  input  logic                     b_empty,
  output logic                     b_rd_en,
  input  logic [FC_WORD_WIDTH-1:0] op_dout,
  input  logic                     op_empty,
  output logic                     op_rd_en,
  output logic [FC_WORD_WIDTH-1:0] fc_new_data,
  output logic                     fc_weights_valid,
  output logic                     fc_biases_valid,
  output logic                     fc_ops_valid,
  input  logic                     fc_in_rd_en,
  output logic                     busy,
  output logic                     done_out
);

  localparam int GROUP_COUNT = FC_TOTAL_COUNT / FC_LANES;
  localparam int CNT_WIDTH   = (GROUP_COUNT > 1) ? $clog2(GROUP_COUNT) : 1;
  localparam int WORD_BITS   = DATA_WIDTH * FC_LANES;

  fc_loader_state_t state_r;
  fc_loader_state_t state_next_s;

  logic [WORD_BITS-1:0]     word_s;
  logic [FC_WORD_WIDTH-1:0] b_word_s;
  logic                     b_empty_s;
  logic                     weights_valid_s;
  logic                     biases_valid_s;
  logic                     ops_valid_s;
  logic                     w_pop_s;
  logic                     b_pop_s;
  logic                     op_pop_s;
  logic                     cnt_clear_s;
  logic                     cnt_inc_s;
  logic                     cnt_terminal_s;
  logic [CNT_WIDTH-1:0]     group_cnt_s;
  logic                     busy_r;
  logic                     done_r;
  logic                     busy_next_s;
  logic                     done_next_s;
  logic                     unused_s;

`ifdef FC_LOADER_ZERO_BIAS_EN
  localparam fc_loader_state_t AFTER_WEIGHTS = FC_LOAD_OP;

  // The FC stage's bias registers stay at their reset value of zero.
  assign b_empty_s       = 1'b1;
  assign b_word_s        = '0;
  assign b_rd_en         = 1'b0;
  assign fc_biases_valid = 1'b0;
  assign unused_s        = ^{group_cnt_s, b_dout, b_empty, b_pop_s, biases_valid_s};
`else
  localparam fc_loader_state_t AFTER_WEIGHTS = FC_LOAD_B;

  assign b_empty_s       = b_empty;
  assign b_word_s        = b_dout;
  assign b_rd_en         = b_pop_s;
  assign fc_biases_valid = biases_valid_s;
  assign unused_s        = ^group_cnt_s;
`endif

  fc_group_counter #(
    .WIDTH    (CNT_WIDTH),
    .TERMINAL (GROUP_COUNT - 1)
  ) u_group_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear_s),
    .inc      (cnt_inc_s),
    .count    (group_cnt_s),
    .terminal (cnt_terminal_s)
  );

  // State register plus registered status flags tracking the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= FC_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
      done_r  <= done_next_s;
    end
  end

  // Next state, FIFO pops and the word offered to the FC stage (direct from the FIFO heads).
  always_comb begin
    state_next_s    = state_r;
    word_s          = '0;
    weights_valid_s = 1'b0;
    biases_valid_s  = 1'b0;
    ops_valid_s     = 1'b0;
    w_pop_s         = 1'b0;
    b_pop_s         = 1'b0;
    op_pop_s        = 1'b0;
    cnt_clear_s     = 1'b0;
    cnt_inc_s       = 1'b0;
    if (reset) begin
      state_next_s = FC_IDLE;
    end else begin
      case (state_r)
        FC_IDLE, FC_DONE: begin
          if (start) begin
            state_next_s = FC_LOAD_W;
            cnt_clear_s  = 1'b1;
          end else begin
            state_next_s = state_r;
          end
        end
        FC_LOAD_W: begin
          if (!w_empty) begin
            word_s          = w_dout;
            weights_valid_s = 1'b1;
            w_pop_s         = 1'b1;
            state_next_s    = AFTER_WEIGHTS;
          end else begin
            state_next_s = state_r;
          end
        end
        FC_LOAD_B: begin
          if (!b_empty_s) begin
            word_s         = b_word_s;
            biases_valid_s = 1'b1;
            b_pop_s        = 1'b1;
            state_next_s   = FC_LOAD_OP;
          end else begin
            state_next_s = state_r;
          end
        end
        FC_LOAD_OP: begin
          if (!op_empty) begin
            word_s       = op_dout;
            ops_valid_s  = 1'b1;
            op_pop_s     = 1'b1;
            state_next_s = FC_WAIT_ACK;
          end else begin
            state_next_s = state_r;
          end
        end
        FC_WAIT_ACK: begin
          if (fc_in_rd_en) begin
            if (cnt_terminal_s) begin
              state_next_s = FC_DONE;
            end else begin
              cnt_inc_s    = 1'b1;
              state_next_s = FC_LOAD_W;
            end
          end else begin
            state_next_s = state_r;
          end
        end
        default: begin
          state_next_s = FC_IDLE;
        end
      endcase
    end
    busy_next_s = (state_next_s != FC_IDLE) && (state_next_s != FC_DONE);
    done_next_s = (state_next_s == FC_DONE);
  end

  assign fc_new_data      = word_s;
  assign fc_weights_valid = weights_valid_s;
  assign fc_ops_valid     = ops_valid_s;
  assign w_rd_en          = w_pop_s;
  assign op_rd_en         = op_pop_s;
  assign busy             = busy_r;
  assign done_out         = done_r;

endmodule
